// File: rtl/uart_tx_if.sv
// Transmit-side bundle between uart_tx and its fifo / baud generator.
// master is the transmitter's view; slave is the surrounding system's view.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 b_tick;
  logic                 tx_en;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_rd_en;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    input  b_tick, tx_en, fifo_empty, fifo_data,
    output fifo_rd_en, tx, tx_busy, tx_done
  );

  modport slave (
    output b_tick, tx_en, fifo_empty, fifo_data,
    input  fifo_rd_en, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a fifo and serialises start, data (LSB first),
// optional even parity and stop bits, timed by the shared oversampling b_tick.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_EN  = 1
) (
  input  logic     clock,
  input  logic     reset,
  uart_tx_if.master bus
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par, par_n;
  logic                 tx_q, tx_n;
  logic                 rd_en, done, bit_end;

  assign bit_end = bus.b_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      par      <= par_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par;
    rd_en   = 1'b0;
    done    = 1'b0;
    tx_n    = 1'b1;

    if (bus.b_tick && (state inside {START, DATA, PARITY, STOP}))
      tick_n = bit_end ? '0 : tick_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (bus.tx_en && !bus.fifo_empty && !reset) begin
          rd_en   = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shift_n = bus.fifo_data;
        par_n   = ^bus.fifo_data;
        tick_n  = '0;
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            done    = 1'b1;
            bit_n   = '0;
            state_n = IDLE;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is registered from the next state so the line level always matches the state it belongs to
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.tx         = tx_q;
  assign bus.tx_busy    = (state != IDLE);
  assign bus.tx_done    = done;

endmodule
